// File: rtl/tmp_seq_ctrl_if.sv
// Signal bundle between the temperature-sensor phase sequencer and the analog front end.
// The master side is the sequencer: it takes run enable and comparator and drives the switches.
interface tmp_seq_ctrl_if #(
    parameter int RES_W = 5
) ();
    logic             en;
    logic             cmp;
    logic             PII1;
    logic             PII2;
    logic             PI1;
    logic             PI2;
    logic             PA;
    logic             PB;
    logic             PC;
    logic             PD;
    logic             src_n;
    logic             snk;
    logic             preChrg;
    logic             rst;
    logic             valid;
    logic [RES_W-1:0] result;

    modport master (
        input  en,
        input  cmp,
        output PII1, PII2, PI1, PI2, PA, PB, PC, PD,
        output src_n, snk, preChrg, rst, valid, result
    );

    modport slave (
        output en,
        output cmp,
        input  PII1, PII2, PI1, PI2, PA, PB, PC, PD,
        input  src_n, snk, preChrg, rst, valid, result
    );
endinterface

// File: rtl/tmp_seq_ctrl.sv
// Phase sequencer and decision counter for the switched-capacitor temperature sensor.
// Outputs are decoded from the next state and registered, so every switch control is glitch-free.
module tmp_seq_ctrl #(
    parameter int PHASE_CYC = 3,
    parameter int BLANK_CYC = 2,
    parameter int PRE_CYC   = 2,
    parameter int N_CYC     = 16,
    parameter int RES_W     = 5
) (
    input  logic           clk,
    input  logic           reset,
    tmp_seq_ctrl_if.master bus
);

    localparam int TICK_W = 7;
    localparam logic [TICK_W-1:0] TICK_ZERO  = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [TICK_W-1:0] PRE_LAST   = TICK_W'(PRE_CYC - 1);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_CYC - 1);
    localparam logic [TICK_W-1:0] CORE_LAST  = TICK_W'(PHASE_CYC);
    localparam logic [TICK_W-1:0] PHASE_LAST = TICK_W'(PHASE_CYC + 1);
    localparam logic [RES_W-1:0]  RES_ZERO   = RES_W'(0);
    localparam logic [RES_W-1:0]  RES_ONE    = RES_W'(1);
    localparam logic [RES_W-1:0]  CYC_LAST   = RES_W'(N_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRECHARGE, S_BLANK, S_DIODE, S_BIGDIODE, S_HCHARGE, S_LCHARGE, S_OUTPUT
    } state_t;

    // Which phase the current blank gap leads into.
    typedef enum logic [1:0] {
        STEP_DIODE, STEP_BIG, STEP_CHARGE
    } step_t;

    state_t             state_r;
    state_t             state_nxt_s;
    step_t              step_r;
    step_t              step_nxt_s;
    logic [TICK_W-1:0]  tick_r;
    logic [TICK_W-1:0]  tick_nxt_s;
    logic [RES_W-1:0]   cyc_r;
    logic [RES_W-1:0]   cyc_nxt_s;
    logic [RES_W-1:0]   dec_r;
    logic [RES_W-1:0]   dec_nxt_s;
    logic               cmp_meta_r;
    logic               cmp_sync_r;

    logic               core_s;
    logic               pre_nxt_s;
    logic               pii1_nxt_s;
    logic               pii2_nxt_s;
    logic               pi1_nxt_s;
    logic               pi2_nxt_s;
    logic               pa_nxt_s;
    logic               pb_nxt_s;
    logic               pc_nxt_s;
    logic               pd_nxt_s;
    logic               src_n_nxt_s;
    logic               snk_nxt_s;
    logic               valid_nxt_s;

    logic               rst_r;
    logic               pre_r;
    logic               pii1_r;
    logic               pii2_r;
    logic               pi1_r;
    logic               pi2_r;
    logic               pa_r;
    logic               pb_r;
    logic               pc_r;
    logic               pd_r;
    logic               src_n_r;
    logic               snk_r;
    logic               valid_r;
    logic [RES_W-1:0]   result_r;

    // Next-state, phase tick, conversion-cycle and decision-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        tick_nxt_s  = tick_r + TICK_ONE;
        cyc_nxt_s   = cyc_r;
        dec_nxt_s   = dec_r;
        case (state_r)
            S_IDLE: begin
                tick_nxt_s = TICK_ZERO;
                if (bus.en) begin
                    state_nxt_s = S_PRECHARGE;
                    cyc_nxt_s   = RES_ZERO;
                    dec_nxt_s   = RES_ZERO;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_PRECHARGE: begin
                if (tick_r == PRE_LAST) begin
                    state_nxt_s = S_BLANK;
                    step_nxt_s  = STEP_DIODE;
                    tick_nxt_s  = TICK_ZERO;
                end else begin
                    state_nxt_s = S_PRECHARGE;
                end
            end
            S_BLANK: begin
                if (tick_r == BLANK_LAST) begin
                    tick_nxt_s = TICK_ZERO;
                    case (step_r)
                        STEP_DIODE: state_nxt_s = S_DIODE;
                        STEP_BIG:   state_nxt_s = S_BIGDIODE;
                        STEP_CHARGE: begin
                            // Comparator high means the integrator is above threshold: discharge.
                            if (cmp_sync_r) begin
                                state_nxt_s = S_LCHARGE;
                                dec_nxt_s   = dec_r + RES_ONE;
                            end else begin
                                state_nxt_s = S_HCHARGE;
                            end
                        end
                        default: state_nxt_s = S_IDLE;
                    endcase
                end else begin
                    state_nxt_s = S_BLANK;
                end
            end
            S_DIODE: begin
                if (tick_r == PHASE_LAST) begin
                    state_nxt_s = S_BLANK;
                    step_nxt_s  = STEP_BIG;
                    tick_nxt_s  = TICK_ZERO;
                end else begin
                    state_nxt_s = S_DIODE;
                end
            end
            S_BIGDIODE: begin
                if (tick_r == PHASE_LAST) begin
                    state_nxt_s = S_BLANK;
                    step_nxt_s  = STEP_CHARGE;
                    tick_nxt_s  = TICK_ZERO;
                end else begin
                    state_nxt_s = S_BIGDIODE;
                end
            end
            S_HCHARGE, S_LCHARGE: begin
                if (tick_r == PHASE_LAST) begin
                    tick_nxt_s = TICK_ZERO;
                    if (cyc_r == CYC_LAST) begin
                        state_nxt_s = S_OUTPUT;
                    end else begin
                        state_nxt_s = S_BLANK;
                        step_nxt_s  = STEP_DIODE;
                        cyc_nxt_s   = cyc_r + RES_ONE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_OUTPUT: begin
                tick_nxt_s = TICK_ZERO;
                if (bus.en) begin
                    state_nxt_s = S_PRECHARGE;
                    cyc_nxt_s   = RES_ZERO;
                    dec_nxt_s   = RES_ZERO;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                tick_nxt_s  = TICK_ZERO;
            end
        endcase
    end

    // Switch decode of the upcoming cycle: lead and trail carry switch 1 only, core carries both.
    always_comb begin
        core_s      = (tick_nxt_s != TICK_ZERO) && (tick_nxt_s <= CORE_LAST);
        pre_nxt_s   = 1'b0;
        pii1_nxt_s  = 1'b0;
        pii2_nxt_s  = 1'b0;
        pi1_nxt_s   = 1'b0;
        pi2_nxt_s   = 1'b0;
        pa_nxt_s    = 1'b0;
        pb_nxt_s    = 1'b0;
        pc_nxt_s    = 1'b0;
        pd_nxt_s    = 1'b0;
        src_n_nxt_s = 1'b1;
        snk_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            S_PRECHARGE: pre_nxt_s = 1'b1;
            S_DIODE: begin
                pii1_nxt_s = 1'b1;
                pii2_nxt_s = core_s;
            end
            S_BIGDIODE: begin
                pi1_nxt_s = 1'b1;
                pi2_nxt_s = core_s;
            end
            S_HCHARGE: begin
                pa_nxt_s    = 1'b1;
                pb_nxt_s    = core_s;
                src_n_nxt_s = ~core_s;
            end
            S_LCHARGE: begin
                pc_nxt_s  = 1'b1;
                pd_nxt_s  = core_s;
                snk_nxt_s = core_s;
            end
            S_OUTPUT: valid_nxt_s = 1'b1;
            default:  valid_nxt_s = 1'b0;
        endcase
    end

    // Comparator synchroniser and sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_meta_r <= 1'b0;
            cmp_sync_r <= 1'b0;
            state_r    <= S_IDLE;
            step_r     <= STEP_DIODE;
            tick_r     <= TICK_ZERO;
            cyc_r      <= RES_ZERO;
            dec_r      <= RES_ZERO;
        end else begin
            cmp_meta_r <= bus.cmp;
            cmp_sync_r <= cmp_meta_r;
            state_r    <= state_nxt_s;
            step_r     <= step_nxt_s;
            tick_r     <= tick_nxt_s;
            cyc_r      <= cyc_nxt_s;
            dec_r      <= dec_nxt_s;
        end
    end

    // Registered analog controls, result strobe and held result word.
    always_ff @(posedge clk) begin
        rst_r <= reset;
        if (reset) begin
            pre_r    <= 1'b0;
            pii1_r   <= 1'b0;
            pii2_r   <= 1'b0;
            pi1_r    <= 1'b0;
            pi2_r    <= 1'b0;
            pa_r     <= 1'b0;
            pb_r     <= 1'b0;
            pc_r     <= 1'b0;
            pd_r     <= 1'b0;
            src_n_r  <= 1'b1;
            snk_r    <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= RES_ZERO;
        end else begin
            pre_r    <= pre_nxt_s;
            pii1_r   <= pii1_nxt_s;
            pii2_r   <= pii2_nxt_s;
            pi1_r    <= pi1_nxt_s;
            pi2_r    <= pi2_nxt_s;
            pa_r     <= pa_nxt_s;
            pb_r     <= pb_nxt_s;
            pc_r     <= pc_nxt_s;
            pd_r     <= pd_nxt_s;
            src_n_r  <= src_n_nxt_s;
            snk_r    <= snk_nxt_s;
            valid_r  <= valid_nxt_s;
            if (valid_nxt_s) begin
                result_r <= dec_nxt_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign bus.rst     = rst_r;
    assign bus.preChrg = pre_r;
    assign bus.PII1    = pii1_r;
    assign bus.PII2    = pii2_r;
    assign bus.PI1     = pi1_r;
    assign bus.PI2     = pi2_r;
    assign bus.PA      = pa_r;
    assign bus.PB      = pb_r;
    assign bus.PC      = pc_r;
    assign bus.PD      = pd_r;
    assign bus.src_n   = src_n_r;
    assign bus.snk     = snk_r;
    assign bus.valid   = valid_r;
    assign bus.result  = result_r;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// Self-checking bench for tmp_seq_ctrl: per-scenario tasks, a result scoreboard keyed on the
// expected strobe cycle, and a monitor for the switch-group safety invariants.
module tb_tmp_seq_ctrl;

    localparam int PHASE_CYC = 3;
    localparam int BLANK_CYC = 2;
    localparam int PRE_CYC   = 2;
    localparam int N_CYC     = 16;
    localparam int RES_W     = 5;
    localparam int L         = 3 * (PHASE_CYC + 2 + BLANK_CYC);
    localparam int T_VALID   = PRE_CYC + N_CYC * L;
    localparam logic [12:0] IDLE_OUTS = 13'b0100000000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tmp_seq_ctrl_if #(.RES_W(RES_W)) bus ();

    tmp_seq_ctrl #(
        .PHASE_CYC(PHASE_CYC), .BLANK_CYC(BLANK_CYC), .PRE_CYC(PRE_CYC),
        .N_CYC(N_CYC), .RES_W(RES_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               when;
        logic [RES_W-1:0] res;
    } exp_t;

    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;
    exp_t sb_q[$];
    exp_t sb_e;
    bit   mon_en  = 1'b0;
    logic valid_d = 1'b0;
    int   last_grp = 0;
    int   off_run  = 100;
    int   grp_cnt;
    int   grp;
    int   need;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // {rst, src_n, preChrg, PII1, PII2, PI1, PI2, PA, PB, PC, PD, snk, valid}
    function automatic logic [12:0] outs();
        return {bus.rst, bus.src_n, bus.preChrg, bus.PII1, bus.PII2, bus.PI1, bus.PI2,
                bus.PA, bus.PB, bus.PC, bus.PD, bus.snk, bus.valid};
    endfunction

    // Scoreboard: every strobe must match the oldest expected result and cycle.
    always @(negedge clk) begin
        if (mon_en && bus.valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid cycle=%0d result=%0d expected no strobe",
                         cyc_cnt, bus.result);
            end else begin
                sb_e = sb_q.pop_front();
                if (bus.result !== sb_e.res || cyc_cnt != sb_e.when) begin
                    errors++;
                    $display("FAIL sb_result got result=%0d at cycle %0d expected result=%0d at cycle %0d",
                             bus.result, cyc_cnt, sb_e.res, sb_e.when);
                end
            end
        end
    end

    // Invariant monitor: group exclusivity, blank gaps, source/sink exclusivity, strobe width.
    always @(negedge clk) begin
        if (mon_en) begin
            grp_cnt = int'(bus.PII1 | bus.PII2) + int'(bus.PI1 | bus.PI2) + int'(bus.PA | bus.PB)
                    + int'(bus.PC | bus.PD) + int'(bus.preChrg);
            checks++;
            if (grp_cnt > 1) begin
                errors++;
                $display("FAIL group_overlap cycle=%0d active_groups=%0d expected <=1", cyc_cnt, grp_cnt);
            end
            checks++;
            if (bus.src_n === 1'b0 && bus.snk === 1'b1) begin
                errors++;
                $display("FAIL src_snk_overlap cycle=%0d src_n=0 snk=1 expected not both", cyc_cnt);
            end
            checks++;
            if (bus.valid === 1'b1 && valid_d === 1'b1) begin
                errors++;
                $display("FAIL valid_width cycle=%0d valid high 2 cycles expected 1", cyc_cnt);
            end
            grp = (bus.PII1 | bus.PII2) ? 1 : (bus.PI1 | bus.PI2) ? 2 : (bus.PA | bus.PB) ? 3 :
                  (bus.PC | bus.PD) ? 4 : bus.preChrg ? 5 : 0;
            if (grp == 0) begin
                off_run++;
            end else begin
                if (grp != last_grp && last_grp != 0) begin
                    // Precharge follows the one-cycle result strobe directly in continuous mode.
                    need = (grp == 5) ? 1 : BLANK_CYC;
                    checks++;
                    if (off_run < need) begin
                        errors++;
                        $display("FAIL blank_gap cycle=%0d gap=%0d expected >=%0d", cyc_cnt, off_run, need);
                    end
                end
                last_grp = grp;
                off_run  = 0;
            end
            valid_d = bus.valid;
        end
    end

    task automatic test_reset();
        reset = 1'b1; bus.en = 1'b0; bus.cmp = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        checks++;
        if (outs() !== 13'b1100000000000 || bus.result !== RES_W'(0)) begin
            errors++;
            $display("FAIL reset_state got outs=%b result=%0d expected outs=1100000000000 result=0",
                     outs(), bus.result);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL idle_state got outs=%b expected %b", outs(), IDLE_OUTS);
        end
    endtask

    task automatic test_cmp_low();
        logic [12:0] exp_o;
        bus.en = 1'b1; bus.cmp = 1'b0;
        sb_q.push_back('{when: cyc_cnt + 1 + T_VALID, res: RES_W'(0)});
        for (int t = 0; t <= T_VALID + 1; t++) begin
            @(negedge clk);
            if (t < PRE_CYC + L) begin
                exp_o = IDLE_OUTS;
                exp_o[10] = (t <= 1);
                exp_o[9]  = (t >= 4 && t <= 8);
                exp_o[8]  = (t >= 5 && t <= 7);
                exp_o[7]  = (t >= 11 && t <= 15);
                exp_o[6]  = (t >= 12 && t <= 14);
                exp_o[5]  = (t >= 18 && t <= 22);
                exp_o[4]  = (t >= 19 && t <= 21);
                exp_o[11] = !(t >= 19 && t <= 21);
                checks++;
                if (outs() !== exp_o) begin
                    errors++;
                    $display("FAIL low_cycle0 t=%0d got outs=%b expected %b", t, outs(), exp_o);
                end
            end
            if (t == T_VALID + 1) begin
                checks++;
                if (outs() !== IDLE_OUTS) begin
                    errors++;
                    $display("FAIL low_return_idle got outs=%b expected %b", outs(), IDLE_OUTS);
                end
            end
            if (t == 100) bus.en = 1'b0;
        end
    endtask

    task automatic test_cmp_high();
        int snk_n = 0, srcl_n = 0, pc_n = 0, pa_n = 0;
        bus.en = 1'b1; bus.cmp = 1'b1;
        sb_q.push_back('{when: cyc_cnt + 1 + T_VALID, res: RES_W'(N_CYC)});
        for (int t = 0; t <= T_VALID + 1; t++) begin
            @(negedge clk);
            snk_n  += int'(bus.snk);
            srcl_n += int'(!bus.src_n);
            pc_n   += int'(bus.PC);
            pa_n   += int'(bus.PA);
            if (t == 5) bus.en = 1'b0;
        end
        checks++;
        if (snk_n != N_CYC * PHASE_CYC || srcl_n != 0 || pc_n != N_CYC * (PHASE_CYC + 2) || pa_n != 0) begin
            errors++;
            $display("FAIL high_phases got snk=%0d src_low=%0d PC=%0d PA=%0d expected %0d 0 %0d 0",
                     snk_n, srcl_n, pc_n, pa_n, N_CYC * PHASE_CYC, N_CYC * (PHASE_CYC + 2));
        end
    endtask

    task automatic test_toggle_continuous();
        int rel;
        int base;
        bus.en = 1'b1; bus.cmp = 1'b0;
        sb_q.push_back('{when: cyc_cnt + 1 + T_VALID, res: RES_W'(N_CYC / 2)});
        sb_q.push_back('{when: cyc_cnt + 1 + 2 * T_VALID + 1, res: RES_W'(N_CYC / 2)});
        for (int t = 0; t <= 2 * T_VALID + 2; t++) begin
            @(negedge clk);
            if (t == T_VALID || t == T_VALID + 1 || t == 2 * T_VALID + 2) begin
                checks++;
                if (bus.preChrg !== ((t == T_VALID + 1) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL toggle_prechrg t=%0d got %b expected %b", t, bus.preChrg,
                             (t == T_VALID + 1) ? 1'b1 : 1'b0);
                end
            end
            base = (t > T_VALID) ? T_VALID + 1 : 0;
            rel  = t - base - PRE_CYC;
            if (rel >= 0 && rel % L == 0) bus.cmp = ((rel / L) % 2 == 1);
            if (t == 400) bus.en = 1'b0;
        end
    endtask

    task automatic test_single_shot();
        bus.en = 1'b1; bus.cmp = 1'b1;
        sb_q.push_back('{when: cyc_cnt + 1 + T_VALID, res: RES_W'(N_CYC)});
        for (int t = 0; t <= T_VALID + 30; t++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (t > T_VALID) begin
                checks++;
                if (outs() !== IDLE_OUTS) begin
                    errors++;
                    $display("FAIL single_idle t=%0d got outs=%b expected %b", t, outs(), IDLE_OUTS);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.en = 1'b1; bus.cmp = 1'b0;
        for (int t = 0; t <= 400; t++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (t == 13) begin
                checks++;
                if (bus.PI1 !== 1'b1 || bus.PI2 !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_bigdiode got PI1=%b PI2=%b expected 1 1", bus.PI1, bus.PI2);
                end
                reset = 1'b1;
            end
            if (t == 14) begin
                checks++;
                if (outs() !== 13'b1100000000000 || bus.result !== RES_W'(0)) begin
                    errors++;
                    $display("FAIL abort_reset got outs=%b result=%0d expected 1100000000000 0",
                             outs(), bus.result);
                end
                reset = 1'b0;
            end
            if (t == 15) begin
                checks++;
                if (outs() !== IDLE_OUTS) begin
                    errors++;
                    $display("FAIL abort_release got outs=%b expected %b", outs(), IDLE_OUTS);
                end
            end
        end
        bus.en = 1'b1; bus.cmp = 1'b1;
        sb_q.push_back('{when: cyc_cnt + 1 + T_VALID, res: RES_W'(N_CYC)});
        for (int t = 0; t <= T_VALID + 1; t++) begin
            @(negedge clk);
            bus.en = 1'b0;
        end
    endtask

    task automatic test_random();
        logic rbits[3][N_CYC];
        int   sum;
        int   j;
        int   rel;
        bus.en = 1'b1; bus.cmp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sum = 0;
            for (int k = 0; k < N_CYC; k++) begin
                rbits[c][k] = 1'($urandom_range(0, 1));
                sum += int'(rbits[c][k]);
            end
            sb_q.push_back('{when: cyc_cnt + 1 + T_VALID + c * (T_VALID + 1), res: RES_W'(sum)});
        end
        for (int t = 0; t <= 3 * (T_VALID + 1); t++) begin
            @(negedge clk);
            j   = t / (T_VALID + 1);
            rel = t - j * (T_VALID + 1) - PRE_CYC;
            if (j < 3 && rel >= 0 && rel % L == 0 && rel / L < N_CYC) bus.cmp = rbits[j][rel / L];
            if (t == 2 * (T_VALID + 1) + 5) bus.en = 1'b0;
        end
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL random_end_idle got outs=%b expected %b", outs(), IDLE_OUTS);
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.cmp = 1'b0;
        test_reset();
        test_cmp_low();
        test_cmp_high();
        test_toggle_continuous();
        test_single_shot();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got %0d outstanding results expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
